vga_ram_port_arbiter: RTL and testbench

- Shares the single 32-bit on-chip frame-statistics RAM port (vga_ram_*: 12-bit word address, chipselect, clken, write, writedata, byteenable, readdata) between two fabric requesters.
- Requester A is the VGA capture writer. Requester B is the LED colour engine, which does reads and read-modify-writes.
- Requester side is Avalon-MM-style (waitrequest, readdatavalid). The block sits between the two fabric masters and the soc_system vga_ram slave.

---
 rtl/vga_ram_port_arbiter_if.sv | 53 +++++
 rtl/vga_ram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_vga_ram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_ram_port_arbiter_if.sv
// Requester A/B Avalon-style ports plus the shared vga_ram port, bundled for vga_ram_port_arbiter.
interface vga_ram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  a_req;
  logic                  a_write;
  logic                  a_lock;
  logic [ADDR_W-1:0]     a_address;
  logic [DATA_W-1:0]     a_writedata;
  logic [DATA_W/8-1:0]   a_byteenable;
  logic                  a_waitrequest;
  logic                  a_readdatavalid;
  logic [DATA_W-1:0]     a_readdata;

  logic                  b_req;
  logic                  b_write;
  logic                  b_lock;
  logic [ADDR_W-1:0]     b_address;
  logic [DATA_W-1:0]     b_writedata;
  logic [DATA_W/8-1:0]   b_byteenable;
  logic                  b_waitrequest;
  logic                  b_readdatavalid;
  logic [DATA_W-1:0]     b_readdata;

  logic [ADDR_W-1:0]     vga_ram_address;
  logic                  vga_ram_chipselect;
  logic                  vga_ram_clken;
  logic                  vga_ram_write;
  logic [DATA_W-1:0]     vga_ram_writedata;
  logic [DATA_W/8-1:0]   vga_ram_byteenable;
  logic [DATA_W-1:0]     vga_ram_readdata;

  modport slave (
    input  a_req, a_write, a_lock, a_address, a_writedata, a_byteenable,
    output a_waitrequest, a_readdatavalid, a_readdata,
    input  b_req, b_write, b_lock, b_address, b_writedata, b_byteenable,
    output b_waitrequest, b_readdatavalid, b_readdata,
    output vga_ram_address, vga_ram_chipselect, vga_ram_clken, vga_ram_write,
    output vga_ram_writedata, vga_ram_byteenable,
    input  vga_ram_readdata
  );

  modport master (
    output a_req, a_write, a_lock, a_address, a_writedata, a_byteenable,
    input  a_waitrequest, a_readdatavalid, a_readdata,
    output b_req, b_write, b_lock, b_address, b_writedata, b_byteenable,
    input  b_waitrequest, b_readdatavalid, b_readdata,
    input  vga_ram_address, vga_ram_chipselect, vga_ram_clken, vga_ram_write,
    input  vga_ram_writedata, vga_ram_byteenable,
    output vga_ram_readdata
  );
endinterface

// File: rtl/vga_ram_port_arbiter.sv
// Two-requester arbiter (round-robin + lock) for the single vga_ram port, with in-order read return.
// Define VGA_RAM_ARB_A_PRIORITY_EN to make A win every IDLE tie instead of round-robin.
module vga_ram_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 15
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  vga_ram_port_arbiter_if.slave bus
);
  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic             SEL_A   = 1'b0;
  localparam logic             SEL_B   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;

  logic grant_a_s;
  logic grant_b_s;
  logic rd_accept_s;
  logic ret_vld_s;

  // State, arbitration history and read-return tag pipeline
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= ST_IDLE;
      last_winner_q <= SEL_B;
      lock_cnt_q    <= CNT_ZERO;
      tag_vld_q     <= {RD_LATENCY{1'b0}};
      tag_own_q     <= {RD_LATENCY{1'b0}};
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
      tag_vld_q     <= tag_vld_d;
      tag_own_q     <= tag_own_d;
    end
  end

  // Next state: lock entry/exit, beat counting under lock, tag shift
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;

    if (grant_a_s) begin
      last_winner_d = SEL_A;
    end else if (grant_b_s) begin
      last_winner_d = SEL_B;
    end else begin
      last_winner_d = last_winner_q;
    end

    case (state_q)
      ST_IDLE: begin
        // The entering beat is beat 1 of the lock
        if ((grant_a_s && bus.a_lock) || (grant_b_s && bus.b_lock)) begin
          if (CNT_ONE >= CNT_MAX) begin
            state_d    = ST_IDLE;
            lock_cnt_d = CNT_ZERO;
          end else begin
            state_d    = grant_a_s ? ST_LOCK_A : ST_LOCK_B;
            lock_cnt_d = CNT_ONE;
          end
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = CNT_ZERO;
        end
      end
      ST_LOCK_A: begin
        if (grant_a_s) begin
          if (!bus.a_lock || ((lock_cnt_q + CNT_ONE) >= CNT_MAX)) begin
            state_d    = ST_IDLE;
            lock_cnt_d = CNT_ZERO;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end else if (!bus.a_req && !bus.a_lock) begin
          state_d    = ST_IDLE;
          lock_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_LOCK_A;
        end
      end
      ST_LOCK_B: begin
        if (grant_b_s) begin
          if (!bus.b_lock || ((lock_cnt_q + CNT_ONE) >= CNT_MAX)) begin
            state_d    = ST_IDLE;
            lock_cnt_d = CNT_ZERO;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end else if (!bus.b_req && !bus.b_lock) begin
          state_d    = ST_IDLE;
          lock_cnt_d = CNT_ZERO;
        end else begin
          state_d = ST_LOCK_B;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = CNT_ZERO;
      end
    endcase

    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = rd_accept_s;
    tag_own_d[0] = grant_b_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // Outputs: grant decision, waitrequest, RAM mux, read-return routing
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (reset_reset_n) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.a_req && bus.b_req) begin
`ifdef VGA_RAM_ARB_A_PRIORITY_EN
            grant_a_s = 1'b1;
            grant_b_s = 1'b0;
`else
            grant_a_s = (last_winner_q == SEL_B);
            grant_b_s = (last_winner_q == SEL_A);
`endif
          end else begin
            grant_a_s = bus.a_req;
            grant_b_s = bus.b_req;
          end
        end
        ST_LOCK_A: grant_a_s = bus.a_req;
        ST_LOCK_B: grant_b_s = bus.b_req;
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end

    bus.a_waitrequest      = ~grant_a_s;
    bus.b_waitrequest      = ~grant_b_s;
    bus.vga_ram_chipselect = grant_a_s | grant_b_s;
    bus.vga_ram_clken      = 1'b1;

    if (grant_b_s) begin
      bus.vga_ram_address    = bus.b_address;
      bus.vga_ram_write      = bus.b_write;
      bus.vga_ram_writedata  = bus.b_writedata;
      bus.vga_ram_byteenable = bus.b_byteenable;
    end else begin
      bus.vga_ram_address    = bus.a_address;
      bus.vga_ram_write      = grant_a_s & bus.a_write;
      bus.vga_ram_writedata  = bus.a_writedata;
      bus.vga_ram_byteenable = bus.a_byteenable;
    end

    rd_accept_s = (grant_a_s & ~bus.a_write) | (grant_b_s & ~bus.b_write);

    ret_vld_s           = tag_vld_q[RD_LATENCY-1] & reset_reset_n;
    bus.a_readdatavalid = ret_vld_s & (tag_own_q[RD_LATENCY-1] == SEL_A);
    bus.b_readdatavalid = ret_vld_s & (tag_own_q[RD_LATENCY-1] == SEL_B);
    bus.a_readdata      = bus.vga_ram_readdata;
    bus.b_readdata      = bus.vga_ram_readdata;
  end
endmodule

// File: tb/tb_vga_ram_port_arbiter.sv
// Bench for vga_ram_port_arbiter: vector table, directed lock/latency/reset sequences, random traffic vs a reference model.
`timescale 1ns/1ps
module tb_vga_ram_port_arbiter;
  localparam int ADDR_W = 12, DATA_W = 32, MAX_LOCK = 15;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic rst2_n;
  always #5 clk_clk = ~clk_clk;

  vga_ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
  vga_ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  vga_ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1), .MAX_LOCK(MAX_LOCK)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .bus(bus1));
  vga_ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .MAX_LOCK(MAX_LOCK)) dut2 (
    .clk_clk(clk_clk), .reset_reset_n(rst2_n), .bus(bus2));

  // Write-first RAM, one cycle read latency
  bit [31:0] ram [0:4095];
  bit [31:0] ram_rd_q;
  always @(posedge clk_clk) begin
    if (bus1.vga_ram_chipselect && bus1.vga_ram_clken) begin
      if (bus1.vga_ram_write) begin
        for (int i = 0; i < 4; i++) begin
          if (bus1.vga_ram_byteenable[i]) ram[bus1.vga_ram_address][8*i +: 8] <= bus1.vga_ram_writedata[8*i +: 8];
        end
      end else begin
        ram_rd_q <= ram[bus1.vga_ram_address];
      end
    end
  end
  assign bus1.vga_ram_readdata = ram_rd_q;
  assign bus2.vga_ram_readdata = 32'h0BAD0BAD;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of the lock (-1 none), beats granted in it, last winner, memory, expected returns
  typedef struct { int owner; int due; bit [31:0] data; } ret_t;
  int        m_lock_owner, m_lock_beats, m_last, cyc;
  bit [31:0] m_mem [0:4095];
  ret_t      rq[$];
  bit        g_a, g_b;

  task automatic model_reset();
    m_lock_owner = -1; m_lock_beats = 0; m_last = 1; rq.delete();
  endtask

  function automatic int model_winner();
    bit ra = bus1.a_req, rb = bus1.b_req;
    if (m_lock_owner == 0) return ra ? 0 : -1;
    if (m_lock_owner == 1) return rb ? 1 : -1;
    if (ra && rb) begin
`ifdef VGA_RAM_ARB_A_PRIORITY_EN
      return 0;
`else
      return 1 - m_last;
`endif
    end
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic model_update(input int w);
    bit wr, lk, rq_o, lk_o; bit [11:0] ad; bit [31:0] wd; bit [3:0] be;
    if (w >= 0) begin
      wr = (w == 0) ? bus1.a_write : bus1.b_write;
      lk = (w == 0) ? bus1.a_lock : bus1.b_lock;
      ad = (w == 0) ? bus1.a_address : bus1.b_address;
      wd = (w == 0) ? bus1.a_writedata : bus1.b_writedata;
      be = (w == 0) ? bus1.a_byteenable : bus1.b_byteenable;
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_mem[ad][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rq.push_back('{w, cyc + 1, m_mem[ad]});
      end
      m_last = w;
      if (m_lock_owner < 0) begin
        if (lk) begin m_lock_owner = w; m_lock_beats = 1; end
      end else begin
        m_lock_beats++;
        if (!lk) m_lock_owner = -1;
      end
      if (m_lock_owner >= 0 && m_lock_beats >= MAX_LOCK) m_lock_owner = -1;
    end else if (m_lock_owner >= 0) begin
      rq_o = (m_lock_owner == 0) ? bus1.a_req : bus1.b_req;
      lk_o = (m_lock_owner == 0) ? bus1.a_lock : bus1.b_lock;
      if (!rq_o && !lk_o) m_lock_owner = -1;
    end
    if (m_lock_owner < 0) m_lock_beats = 0;
  endtask

  // One clock of dut: called at a negedge with inputs set; checks and advances the model
  task automatic step_cycle();
    int w; bit ea, eb, eva, evb, ewr; bit [31:0] ed; ret_t r;
    #2;
    w = reset_reset_n ? model_winner() : -1;
    ea = (w == 0); eb = (w == 1);
    chk("a_waitrequest", bus1.a_waitrequest, !ea);
    chk("b_waitrequest", bus1.b_waitrequest, !eb);
    chk("ram_chipselect", bus1.vga_ram_chipselect, ea | eb);
    chk("ram_clken", bus1.vga_ram_clken, 1'b1);
    ewr = ea ? bus1.a_write : (eb ? bus1.b_write : 1'b0);
    chk("ram_write", bus1.vga_ram_write, ewr);
    if (ea | eb) begin
      chk("ram_address", bus1.vga_ram_address, ea ? bus1.a_address : bus1.b_address);
      if (ewr) begin
        chk("ram_writedata", bus1.vga_ram_writedata, ea ? bus1.a_writedata : bus1.b_writedata);
        chk("ram_byteenable", bus1.vga_ram_byteenable, ea ? bus1.a_byteenable : bus1.b_byteenable);
      end
    end
    g_a = bus1.a_req && !bus1.a_waitrequest;
    g_b = bus1.b_req && !bus1.b_waitrequest;
    eva = 1'b0; evb = 1'b0; ed = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      eva = reset_reset_n && (r.owner == 0);
      evb = reset_reset_n && (r.owner == 1);
      ed  = r.data;
    end
    chk("a_readdatavalid", bus1.a_readdatavalid, eva);
    chk("b_readdatavalid", bus1.b_readdatavalid, evb);
    if (eva) chk("a_readdata", bus1.a_readdata, ed);
    if (evb) chk("b_readdata", bus1.b_readdata, ed);
    if (!reset_reset_n) model_reset(); else model_update(w);
    cyc++;
    @(negedge clk_clk);
  endtask

  task automatic idle1();
    bus1.a_req = 0; bus1.a_write = 0; bus1.a_lock = 0; bus1.a_address = '0; bus1.a_writedata = '0; bus1.a_byteenable = 4'hF;
    bus1.b_req = 0; bus1.b_write = 0; bus1.b_lock = 0; bus1.b_address = '0; bus1.b_writedata = '0; bus1.b_byteenable = 4'hF;
  endtask

  task automatic idle2();
    bus2.a_req = 0; bus2.a_write = 0; bus2.a_lock = 0; bus2.a_address = '0; bus2.a_writedata = '0; bus2.a_byteenable = 4'hF;
    bus2.b_req = 0; bus2.b_write = 0; bus2.b_lock = 0; bus2.b_address = '0; bus2.b_writedata = '0; bus2.b_byteenable = 4'hF;
  endtask

  task automatic reset1();
    idle1(); reset_reset_n = 0; step_cycle(); reset_reset_n = 1;
  endtask

  typedef struct {
    bit ar, aw, al; bit [11:0] aad;
    bit br, bw, bl; bit [11:0] bad;
    bit ewa, ewb, ecs, ewr; bit [11:0] ead;
  } vec_t;

  initial begin
    vec_t vt[10];
    bit pa, pb;
    int ca, cb;
    bit exp_g;

    reset_reset_n = 0; rst2_n = 0; idle1(); idle2(); model_reset(); cyc = 0;
    @(negedge clk_clk);
    step_cycle();
    step_cycle();
    reset_reset_n = 1; rst2_n = 1;

    // ar aw al aad, br bw bl bad, ewa ewb ecs ewr ead
    vt[0] = '{1,1,0,12'h010, 0,0,0,12'h000, 0,1,1,1,12'h010};
    vt[1] = '{0,0,0,12'h000, 1,0,0,12'h010, 1,0,1,0,12'h010};
    vt[2] = '{0,0,0,12'h000, 0,0,0,12'h000, 1,1,0,0,12'h000};
    vt[3] = '{1,0,0,12'h011, 1,0,0,12'h012, 0,1,1,0,12'h011};
    vt[4] = '{1,0,1,12'h020, 0,0,0,12'h000, 0,1,1,0,12'h020};
    vt[5] = '{0,0,1,12'h000, 1,0,0,12'h030, 1,1,0,0,12'h000};
    vt[6] = '{1,0,0,12'h021, 1,0,0,12'h030, 0,1,1,0,12'h021};
    vt[7] = '{0,0,0,12'h000, 1,0,1,12'h031, 1,0,1,0,12'h031};
    vt[8] = '{1,0,0,12'h022, 0,0,0,12'h000, 1,1,0,0,12'h000};
    vt[9] = '{1,0,0,12'h022, 0,0,0,12'h000, 0,1,1,0,12'h022};
    bus1.a_writedata = 32'hDEADBEEF; bus1.b_writedata = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      bus1.a_req = vt[i].ar; bus1.a_write = vt[i].aw; bus1.a_lock = vt[i].al; bus1.a_address = vt[i].aad;
      bus1.b_req = vt[i].br; bus1.b_write = vt[i].bw; bus1.b_lock = vt[i].bl; bus1.b_address = vt[i].bad;
      #1;
      chk($sformatf("vec%0d_a_wait", i), bus1.a_waitrequest, vt[i].ewa);
      chk($sformatf("vec%0d_b_wait", i), bus1.b_waitrequest, vt[i].ewb);
      chk($sformatf("vec%0d_cs", i), bus1.vga_ram_chipselect, vt[i].ecs);
      chk($sformatf("vec%0d_wr", i), bus1.vga_ram_write, vt[i].ewr);
      if (vt[i].ecs) chk($sformatf("vec%0d_addr", i), bus1.vga_ram_address, vt[i].ead);
      step_cycle();
    end

    // Both read every cycle: strict alternation from A (round-robin) or A only (priority)
    reset1();
    ca = 0; cb = 0;
    for (int i = 0; i < 8; i++) begin
      bus1.a_req = 1; bus1.a_write = 0; bus1.a_address = 12'h100 + 12'(ca);
      bus1.b_req = 1; bus1.b_write = 0; bus1.b_address = 12'h200 + 12'(cb);
      step_cycle();
`ifdef VGA_RAM_ARB_A_PRIORITY_EN
      exp_g = 1'b1;
`else
      exp_g = (i % 2 == 0);
`endif
      chk($sformatf("alt%0d_grant_a", i), g_a, exp_g);
      if (g_a) ca++;
      if (g_b) cb++;
      if (i == 5) begin
`ifdef VGA_RAM_ARB_A_PRIORITY_EN
        chk("tie6_count_a", ca, 6); chk("tie6_count_b", cb, 0);
`else
        chk("tie6_count_a", ca, 3); chk("tie6_count_b", cb, 3);
`endif
      end
    end

    // Locked read-modify-write by B at 0x055 while A waits
    reset1();
    bus1.a_req = 1; bus1.a_write = 1; bus1.a_address = 12'h055; bus1.a_writedata = 32'h11223344; bus1.a_byteenable = 4'hF;
    step_cycle();
    idle1();
    bus1.b_req = 1; bus1.b_write = 0; bus1.b_lock = 1; bus1.b_address = 12'h055;
    step_cycle();
    chk("rmw_b_read_grant", g_b, 1'b1);
    bus1.a_req = 1; bus1.a_write = 0; bus1.a_address = 12'h055;
    bus1.b_write = 1; bus1.b_lock = 0; bus1.b_writedata = 32'hCAFEF00D; bus1.b_byteenable = 4'hF;
    #1;
    chk("rmw_a_wait_b_write", bus1.a_waitrequest, 1'b1);
    chk("rmw_b_old_data", bus1.b_readdata, 32'h11223344);
    step_cycle();
    chk("rmw_b_write_grant", g_b, 1'b1);
    bus1.b_req = 0;
    step_cycle();
    chk("rmw_a_after_b", g_a, 1'b1);
    bus1.a_req = 0;
    #1;
    chk("rmw_a_rdv", bus1.a_readdatavalid, 1'b1);
    chk("rmw_new_data", bus1.a_readdata, 32'hCAFEF00D);
    step_cycle();

    // Lock held for 20 beats: broken after MAX_LOCK
    reset1();
    bus1.b_req = 1; bus1.b_lock = 1; bus1.b_write = 0; bus1.b_address = 12'h400;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin bus1.a_req = 1; bus1.a_write = 0; bus1.a_address = 12'h500; end
      step_cycle();
`ifdef VGA_RAM_ARB_A_PRIORITY_EN
      exp_g = (i < 15);
`else
      exp_g = (i != 15);
`endif
      chk($sformatf("lock%0d_grant_b", i), g_b, exp_g);
    end
    idle1();
    step_cycle();

    // Second instance, RD_LATENCY=2: return timing, then reset with a read in flight
    bus2.b_req = 1; bus2.b_address = 12'h001;
    #1 chk("d2_b_grant", bus2.b_waitrequest, 1'b0);
    step_cycle();
    bus2.b_req = 0;
    #1 chk("d2_rdv_lat1", bus2.b_readdatavalid, 1'b0);
    step_cycle();
    #1 chk("d2_rdv_lat2", bus2.b_readdatavalid, 1'b1);
    chk("d2_rdata", bus2.b_readdata, 32'h0BAD0BAD);
    step_cycle();
    bus2.a_req = 1; bus2.a_lock = 1; bus2.a_address = 12'h002;
    #1 chk("d2_a_grant", bus2.a_waitrequest, 1'b0);
    step_cycle();
    bus2.a_req = 0; rst2_n = 0;
    #1 chk("d2_rst_a_wait", bus2.a_waitrequest, 1'b1);
    chk("d2_rst_b_wait", bus2.b_waitrequest, 1'b1);
    step_cycle();
    rst2_n = 1; bus2.b_req = 1; bus2.b_write = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("d2_post%0d_a_rdv", k), bus2.a_readdatavalid, 1'b0);
      chk($sformatf("d2_post%0d_b_rdv", k), bus2.b_readdatavalid, 1'b0);
      if (k == 0) chk("d2_idle_after_reset", bus2.b_waitrequest, 1'b0);
      step_cycle();
      bus2.b_req = 0;
    end

    // Random traffic with held stalled requests and occasional reset
    reset1();
    pa = 0; pb = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!pa) begin
        bus1.a_req = ($urandom_range(0, 3) != 0); bus1.a_write = 1'($urandom_range(0, 1));
        bus1.a_lock = ($urandom_range(0, 2) == 0); bus1.a_address = 12'($urandom_range(0, 15));
        bus1.a_writedata = $urandom; bus1.a_byteenable = 4'($urandom_range(0, 15));
      end
      if (!pb) begin
        bus1.b_req = ($urandom_range(0, 3) != 0); bus1.b_write = 1'($urandom_range(0, 1));
        bus1.b_lock = ($urandom_range(0, 1) == 0); bus1.b_address = 12'($urandom_range(0, 15));
        bus1.b_writedata = $urandom; bus1.b_byteenable = 4'($urandom_range(0, 15));
      end
      reset_reset_n = ($urandom_range(0, 399) != 0);
      step_cycle();
      pa = bus1.a_req && !g_a;
      pb = bus1.b_req && !g_b;
    end
    reset_reset_n = 1;
    idle1();
    step_cycle();
    step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
